// File: rtl/conv_loop_controller_if.sv
// -----------------------------------------------------------------------------
// conv_loop_controller_if
// Groups the feeder handshake, the MAC qualifiers and the result-coordinate
// bus of the convolution loop controller.
//   valid        feeder -> ctrl  operands for the current step are available
//   ready        ctrl -> feeder  controller accepts a step (beat = valid & ready)
//   mac_en       beat accepted this cycle
//   mac_first    beat is the first step of an output (clear accumulator)
//   mac_last     beat is the last step of an output
//   cur_kx/ky    kernel position of the current step
//   cur_ci       input channel of the current step
//   output_valid one-cycle pulse, MAC result valid
//   output_x/y   pixel coordinates of the result
//   output_ch    output channel of the result
// Modports: master = controller side, slave = feeder/MAC/writer side.
// -----------------------------------------------------------------------------
interface conv_loop_controller_if #(
   parameter int FEATURE_MAP_WIDTH  = 128,
   parameter int FEATURE_MAP_HEIGHT = 128,
   parameter int INPUT_NB_CHANNELS  = 2,
   parameter int OUTPUT_NB_CHANNELS = 32,
   parameter int KERNEL_SIZE        = 3
);
   localparam int KW  = (KERNEL_SIZE        > 1) ? $clog2(KERNEL_SIZE)        : 1;
   localparam int CW  = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1;
   localparam int OCW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
   localparam int XW  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
   localparam int YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;

   logic           valid;
   logic           ready;
   logic           mac_en;
   logic           mac_first;
   logic           mac_last;
   logic [KW-1:0]  cur_kx;
   logic [KW-1:0]  cur_ky;
   logic [CW-1:0]  cur_ci;
   logic           output_valid;
   logic [XW-1:0]  output_x;
   logic [YW-1:0]  output_y;
   logic [OCW-1:0] output_ch;

   modport master (
      input  valid,
      output ready, mac_en, mac_first, mac_last,
      output cur_kx, cur_ky, cur_ci,
      output output_valid, output_x, output_y, output_ch
   );

   modport slave (
      output valid,
      input  ready, mac_en, mac_first, mac_last,
      input  cur_kx, cur_ky, cur_ci,
      input  output_valid, output_x, output_y, output_ch
   );
endinterface

// File: rtl/conv_loop_controller.sv
// -----------------------------------------------------------------------------
// conv_loop_controller
// Sequencing FSM for the convolution datapath. On start it walks every output
// pixel / output channel, pacing input beats with a valid/ready handshake, and
// issues MAC qualifiers. Result coordinates travel through a MAC_LATENCY-deep
// shift register so output_valid lines up with the MAC result.
// Ports:
//   clk               clock
//   arst_n            asynchronous active-low reset (aborts a layer at once)
//   start             begin a layer (sampled in IDLE only)
//   running           high from the first RUN cycle until the cycle after the
//                     final output_valid
//   perf_stall_cycles RUN cycles with valid low (0 unless the option is built)
//   ctl               conv_loop_controller_if.master handshake/qualifier bus
// Optional feature macro: CONV_CTRL_PERF_CNT_EN enables the stall counter.
// -----------------------------------------------------------------------------
module conv_loop_controller #(
   parameter int FEATURE_MAP_WIDTH  = 128,
   parameter int FEATURE_MAP_HEIGHT = 128,
   parameter int INPUT_NB_CHANNELS  = 2,
   parameter int OUTPUT_NB_CHANNELS = 32,
   parameter int KERNEL_SIZE        = 3,
   parameter int MAC_LATENCY        = 2
) (
   input  logic                          clk,
   input  logic                          arst_n,
   input  logic                          start,
   output logic                          running,
   output logic [31:0]                   perf_stall_cycles,
   conv_loop_controller_if.master        ctl
);
   localparam int KW  = (KERNEL_SIZE        > 1) ? $clog2(KERNEL_SIZE)        : 1;
   localparam int CW  = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1;
   localparam int OCW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
   localparam int XW  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
   localparam int YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;

   localparam logic [KW-1:0]  K_MAX  = KW'(KERNEL_SIZE - 1);
   localparam logic [CW-1:0]  CI_MAX = CW'(INPUT_NB_CHANNELS - 1);
   localparam logic [OCW-1:0] CO_MAX = OCW'(OUTPUT_NB_CHANNELS - 1);
   localparam logic [XW-1:0]  X_MAX  = XW'(FEATURE_MAP_WIDTH - 1);
   localparam logic [YW-1:0]  Y_MAX  = YW'(FEATURE_MAP_HEIGHT - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_running;
   logic             w_ready;
   logic             w_beat;
   logic             w_start_acc;
   logic             w_mac_first;
   logic             w_mac_last;
   logic             w_all_last;
   logic             w_drain_done;

   logic [KW-1:0]    r_kx;
   logic [KW-1:0]    r_ky;
   logic [CW-1:0]    r_ci;
   logic [OCW-1:0]   r_co;
   logic [XW-1:0]    r_x;
   logic [YW-1:0]    r_y;

   logic             w_kx_max, w_ky_max, w_ci_max, w_co_max, w_x_max, w_y_max;

   logic [MAC_LATENCY-1:0] r_vld_p;
   logic [MAC_LATENCY-1:0] w_pend;
   logic [XW-1:0]          r_x_p  [MAC_LATENCY];
   logic [YW-1:0]          r_y_p  [MAC_LATENCY];
   logic [OCW-1:0]         r_co_p [MAC_LATENCY];

   assign w_kx_max = (r_kx == K_MAX);
   assign w_ky_max = (r_ky == K_MAX);
   assign w_ci_max = (r_ci == CI_MAX);
   assign w_co_max = (r_co == CO_MAX);
   assign w_x_max  = (r_x  == X_MAX);
   assign w_y_max  = (r_y  == Y_MAX);

   // Layer is complete once the final result is at the pipeline output and
   // nothing else is still in flight behind it.
   always_comb begin
      w_pend                  = r_vld_p;
      w_pend[MAC_LATENCY-1]   = 1'b0;
      w_drain_done            = r_vld_p[MAC_LATENCY-1] && (w_pend == '0);
   end

   // ---------------- FSM state register ----------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state   <= S_IDLE;
         r_running <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_running <= (w_state_nxt != S_IDLE);
      end
   end

   // ---------------- FSM next state / outputs ----------------
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_start_acc = 1'b0;
      w_beat      = 1'b0;
      w_all_last  = w_kx_max && w_ky_max && w_ci_max && w_co_max && w_x_max && w_y_max;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_start_acc = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            w_ready = 1'b1;
            w_beat  = ctl.valid;
            if (ctl.valid && w_all_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_drain_done) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_mac_first = w_beat && (r_kx == '0) && (r_ky == '0) && (r_ci == '0);
      w_mac_last  = w_beat && w_kx_max && w_ky_max && w_ci_max;
   end

   // ---------------- loop-nest counters ----------------
   // Innermost first: kx, ky, ci, co, x, y. A level moves only when every
   // level inside it is at its maximum on this beat.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_kx <= '0;
         r_ky <= '0;
         r_ci <= '0;
         r_co <= '0;
         r_x  <= '0;
         r_y  <= '0;
      end else if (w_start_acc) begin
         r_kx <= '0;
         r_ky <= '0;
         r_ci <= '0;
         r_co <= '0;
         r_x  <= '0;
         r_y  <= '0;
      end else if (w_beat) begin
         r_kx <= w_kx_max ? '0 : r_kx + 1'b1;
         if (w_kx_max) begin
            r_ky <= w_ky_max ? '0 : r_ky + 1'b1;
            if (w_ky_max) begin
               r_ci <= w_ci_max ? '0 : r_ci + 1'b1;
               if (w_ci_max) begin
                  r_co <= w_co_max ? '0 : r_co + 1'b1;
                  if (w_co_max) begin
                     r_x <= w_x_max ? '0 : r_x + 1'b1;
                     if (w_x_max) begin
                        r_y <= w_y_max ? '0 : r_y + 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   // ---------------- result pipeline p0 .. p(MAC_LATENCY-1) ----------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_vld_p <= '0;
         for (int i = 0; i < MAC_LATENCY; i++) begin
            r_x_p[i]  <= '0;
            r_y_p[i]  <= '0;
            r_co_p[i] <= '0;
         end
      end else begin
         r_vld_p[0] <= w_mac_last;
         r_x_p[0]   <= r_x;
         r_y_p[0]   <= r_y;
         r_co_p[0]  <= r_co;
         for (int i = 1; i < MAC_LATENCY; i++) begin
            r_vld_p[i] <= r_vld_p[i-1];
            r_x_p[i]   <= r_x_p[i-1];
            r_y_p[i]   <= r_y_p[i-1];
            r_co_p[i]  <= r_co_p[i-1];
         end
      end
   end

`ifdef CONV_CTRL_PERF_CNT_EN
   logic [31:0] r_stall_cnt;

   // Saturating count of RUN cycles in which the feeder had nothing to give.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_stall_cnt <= '0;
      end else if (w_start_acc) begin
         r_stall_cnt <= '0;
      end else if ((r_state == S_RUN) && !ctl.valid && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign perf_stall_cycles = r_stall_cnt;
`else
   assign perf_stall_cycles = 32'd0;
`endif

   assign running          = r_running;
   assign ctl.ready        = w_ready;
   assign ctl.mac_en       = w_beat;
   assign ctl.mac_first    = w_mac_first;
   assign ctl.mac_last     = w_mac_last;
   assign ctl.cur_kx       = r_kx;
   assign ctl.cur_ky       = r_ky;
   assign ctl.cur_ci       = r_ci;
   assign ctl.output_valid = r_vld_p[MAC_LATENCY-1];
   assign ctl.output_x     = r_x_p[MAC_LATENCY-1];
   assign ctl.output_y     = r_y_p[MAC_LATENCY-1];
   assign ctl.output_ch    = r_co_p[MAC_LATENCY-1];

endmodule

// File: doc/conv_loop_controller.md
Name: conv_loop_controller

Overview:
- Sequencing FSM for the convolution datapath. On `start` it walks every output pixel/channel and paces input beats via a valid/ready handshake.
- Issues MAC enable/first/last qualifiers, then emits `output_valid` with `output_x`/`output_y`/`output_ch`, aligned to the MAC pipeline latency.
- Sits between the input feeder, the MAC array and the output writer. Drives the top-level `running` flag.

Parameters:
- FEATURE_MAP_WIDTH, 128, output pixels per row
- FEATURE_MAP_HEIGHT, 128, output rows
- INPUT_NB_CHANNELS, 2, input channels accumulated per output
- OUTPUT_NB_CHANNELS, 32, output channels
- KERNEL_SIZE, 3, square kernel side
- MAC_LATENCY, 2, cycles from accepted beat to MAC result valid (>=1)

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- start  in  1  begin layer (sampled in IDLE only)
- running  out  1  high from first RUN cycle until the cycle after the final output_valid
- valid  in  1  feeder has the operands for the current step
- ready  out  1  controller accepts a step; beat = valid & ready
- mac_en  out  1  beat accepted this cycle (combinational, = valid & ready)
- mac_first  out  1  beat is first step of an output (clear accumulator)
- mac_last  out  1  beat is last step of an output
- cur_kx, cur_ky  out  $clog2(KERNEL_SIZE) each  kernel position of the current step
- cur_ci  out  $clog2(INPUT_NB_CHANNELS)  input channel of the current step
- output_valid  out  1  one-cycle pulse, MAC result valid
- output_x  out  $clog2(FEATURE_MAP_WIDTH)  column of the result
- output_y  out  $clog2(FEATURE_MAP_HEIGHT)  row of the result
- output_ch  out  $clog2(OUTPUT_NB_CHANNELS)  output channel of the result
- perf_stall_cycles  out  32  RUN cycles with valid low (see Optional Feature)

All $clog2 widths are clamped to a minimum of 1.

Behaviour:
- Reset:
  - State IDLE; all counters 0; coordinate pipeline cleared.
  - running, ready, output_valid and perf_stall_cycles are 0.
  - Reset asserted mid-layer aborts immediately; in-flight results are discarded (no output_valid).
- States:
  - IDLE: start=1 -> RUN next cycle, counters zeroed.
  - RUN: ready=1. Each beat advances the loop nest, innermost first: kx, ky, ci, co, x, y. The beat with all counters at max -> DRAIN.
  - DRAIN: ready=0. Stays until the final pixel's output_valid has fired, then -> IDLE next cycle.
- Outputs:
  - running = (state != IDLE), registered.
  - start while RUN/DRAIN is ignored.
- Handshake:
  - Counters advance only on a beat.
  - valid low stalls with no state change.
  - The feeder may hold valid high indefinitely.
- mac_first = beat & kx==0 & ky==0 & ci==0.
- mac_last = beat & all inner counters (kx, ky, ci) at max.
- Result pipeline:
  - MAC_LATENCY-deep shift register of {mac_last, x, y, co}, advanced every cycle.
  - output_valid asserts exactly MAC_LATENCY cycles after a mac_last beat, carrying that beat's coordinates.
  - Back-to-back outputs (steps per output < MAC_LATENCY) are supported.
- Counter wrap: each counter wraps to 0 when it is at max and the next-inner level carries. No overflow beyond FEATURE_MAP_HEIGHT-1.
- Degenerate sizes: KERNEL_SIZE=1, INPUT_NB_CHANNELS=1 -> every beat has mac_first=mac_last=1.

Optional Feature:
- Macro: CONV_CTRL_PERF_CNT_EN.
- Defined:
  - perf_stall_cycles increments each RUN cycle with valid=0.
  - Cleared when start is accepted; holds its value in IDLE; saturates at 2^32-1.
- Undefined: perf_stall_cycles tied to 0; no counter flops.

Test Plan:
- Config W=4, H=3, C=2, OC=2, KS=3, LAT=2; start pulse, valid held 1:
  - 432 beats on consecutive cycles; 24 output_valid pulses.
  - First output_valid 2 cycles after beat 18, with (x,y,ch)=(0,0,0).
  - Second output is (0,0,1); last output is (3,2,1).
  - running falls the cycle after the last pulse.
- Same config, valid toggled 1,0,1,0:
  - Identical output sequence; every gap between output_valid pulses is 36 cycles.
  - With CONV_CTRL_PERF_CNT_EN defined, perf_stall_cycles = 431 at completion.
- KS=1, C=1, LAT=3, W=2, H=1, OC=1, valid held 1:
  - mac_first=mac_last=1 on both beats.
  - output_valid on two consecutive cycles, at 3 and 4 cycles after the first beat.
- start pulsed again mid-RUN and during DRAIN -> ignored; beat count and outputs unchanged.
- arst_n low for 1 cycle after beat 100:
  - All outputs 0 immediately; no output_valid afterwards.
  - A following start runs a full clean layer from (0,0,0).
